// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with programmable modulus, parallel load,
// cascade carry chain and selectable wrap/saturate behaviour at terminal count.
module mod_updown_counter #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             mr,
   input  logic             load,
   input  logic             en,
   input  logic             ci,
   input  logic             dn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             co,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
   localparam bit               SAT_B  = (SATURATE != 0);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             tc_s;
   logic             step_s;

   // Terminal count depends on direction so a dn change moves co in the same cycle
   always_comb begin
      tc_s   = dn ? (cnt_q == ZERO_V) : (cnt_q == MAX_V);
      step_s = en & ci;
   end

   // Next-state selection: load beats count beats hold
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (load) begin
         cnt_d = (d > MAX_V) ? MAX_V : d;
         ovf_d = 1'b0;
      end else if (step_s) begin
         if (tc_s) begin
            ovf_d = 1'b1;
            if (SAT_B) begin
               cnt_d = cnt_q;
            end else begin
               cnt_d = dn ? MAX_V : ZERO_V;
            end
         end else begin
            cnt_d = dn ? (cnt_q - ONE_V) : (cnt_q + ONE_V);
         end
      end else begin
         cnt_d = cnt_q;
         ovf_d = ovf_q;
      end
   end

   // State registers; mr clears immediately and holds them clear while high
   always_ff @(posedge clk or posedge mr) begin
      if (mr) begin
         cnt_q <= ZERO_V;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign q   = cnt_q;
   assign ovf = ovf_q;
   assign co  = step_s & tc_s;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomised and directed bench for mod_updown_counter: five instances (wrap,
// saturate, cascaded tens digit, power-of-two modulus, odd modulus) against a model.
module tb_mod_updown_counter;

   logic       clk = 1'b0;
   logic       mr, load, en, ci, dn;
   logic [4:0] dv;
   logic [3:0] dh;
   logic [3:0] q_w, q_s, q_t;
   logic [2:0] q_p;
   logic [4:0] q_o;
   logic       co_w, co_s, co_t, co_p, co_o;
   logic       ovf_w, ovf_s, ovf_t, ovf_p, ovf_o;

   int errors = 0;
   int checks = 0;
   int mq[5];
   bit movf[5];

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
      .clk(clk), .mr(mr), .load(load), .en(en), .ci(ci), .dn(dn),
      .d(dv[3:0]), .q(q_w), .co(co_w), .ovf(ovf_w));
   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
      .clk(clk), .mr(mr), .load(load), .en(en), .ci(ci), .dn(dn),
      .d(dv[3:0]), .q(q_s), .co(co_s), .ovf(ovf_s));
   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_tens (
      .clk(clk), .mr(mr), .load(load), .en(en), .ci(co_w), .dn(dn),
      .d(dh), .q(q_t), .co(co_t), .ovf(ovf_t));
   mod_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_pow (
      .clk(clk), .mr(mr), .load(load), .en(en), .ci(ci), .dn(dn),
      .d(dv[2:0]), .q(q_p), .co(co_p), .ovf(ovf_p));
   mod_updown_counter #(.WIDTH(5), .MODULUS(13), .SATURATE(1)) u_odd (
      .clk(clk), .mr(mr), .load(load), .en(en), .ci(ci), .dn(dn),
      .d(dv), .q(q_o), .co(co_o), .ovf(ovf_o));

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   function automatic int mod_of(int k);
      case (k)
         3:       return 8;
         4:       return 13;
         default: return 10;
      endcase
   endfunction

   function automatic bit sat_of(int k);
      return (k == 1) || (k == 4);
   endfunction

   function automatic int din_of(int k);
      case (k)
         2:       return int'(dh);
         3:       return int'(dv) % 8;
         4:       return int'(dv);
         default: return int'(dv) % 16;
      endcase
   endfunction

   function automatic bit m_co(int k);
      bit cin;
      cin = (k == 2) ? m_co(0) : bit'(ci);
      return en && cin && (dn ? (mq[k] == 0) : (mq[k] == mod_of(k) - 1));
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 5; k++) begin
         mq[k]   = 0;
         movf[k] = 1'b0;
      end
   endtask

   // One rising edge of the whole system, using pre-edge values for the chain
   task automatic m_edge();
      bit step[5];
      int m;
      if (mr) begin
         m_reset();
      end else begin
         for (int k = 0; k < 5; k++)
            step[k] = en && ((k == 2) ? m_co(0) : bit'(ci));
         for (int k = 0; k < 5; k++) begin
            m = mod_of(k);
            if (load) begin
               mq[k]   = (din_of(k) > m - 1) ? m - 1 : din_of(k);
               movf[k] = 1'b0;
            end else if (step[k]) begin
               if (dn) begin
                  if (mq[k] == 0) begin
                     movf[k] = 1'b1;
                     mq[k]   = sat_of(k) ? 0 : m - 1;
                  end else mq[k] = mq[k] - 1;
               end else begin
                  if (mq[k] == m - 1) begin
                     movf[k] = 1'b1;
                     mq[k]   = sat_of(k) ? m - 1 : 0;
                  end else mq[k] = mq[k] + 1;
               end
            end
         end
      end
   endtask

   function automatic int act_q(int k);
      case (k)
         0: return int'(q_w);
         1: return int'(q_s);
         2: return int'(q_t);
         3: return int'(q_p);
         default: return int'(q_o);
      endcase
   endfunction

   function automatic int act_ovf(int k);
      case (k)
         0: return int'(ovf_w);
         1: return int'(ovf_s);
         2: return int'(ovf_t);
         3: return int'(ovf_p);
         default: return int'(ovf_o);
      endcase
   endfunction

   function automatic int act_co(int k);
      case (k)
         0: return int'(co_w);
         1: return int'(co_s);
         2: return int'(co_t);
         3: return int'(co_p);
         default: return int'(co_o);
      endcase
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison, mid-low-phase after inputs have settled
   always @(negedge clk) begin
      #2;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("q[%0d]", k),   act_q(k),   mq[k]);
         chk($sformatf("ovf[%0d]", k), act_ovf(k), int'(movf[k]));
         chk($sformatf("co[%0d]", k),  act_co(k),  int'(m_co(k)));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drv(bit l, bit e, bit c, bit d_n, int a, int b);
      @(negedge clk);
      #1;
      load = l; en = e; ci = c; dn = d_n;
      dv = a[4:0]; dh = b[3:0];
   endtask

   task automatic tick();
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic step(bit l, bit e, bit c, bit d_n, int a, int b);
      drv(l, e, c, d_n, a, b);
      tick();
   endtask

   // mr raised between edges, held across one edge, dropped just after that edge
   task automatic async_reset(bit lit);
      @(negedge clk);
      #1;
      mr = 1'b1;
      m_reset();
      #1;
      if (lit) begin
         chk("async_q_w", int'(q_w), 0);
         chk("async_ovf_w", int'(ovf_w), 0);
      end
      tick();
      mr = 1'b0;
   endtask

   initial begin
      mr = 1'b1; load = 1'b1; en = 1'b0; ci = 1'b1; dn = 1'b0; dv = 5'd3; dh = 4'd0;
      m_reset();
      #2;
      chk("rst_q", int'(q_w), 0);
      chk("rst_ovf", int'(ovf_w), 0);
      tick();
      mr = 1'b0;
      step(1'b1, 1'b0, 1'b1, 1'b0, 3, 0);
      chk("load3", int'(q_w), 3);
      step(1'b1, 1'b0, 1'b1, 1'b0, 12, 0);
      chk("clamp12", int'(q_w), 9);
      chk("clamp12_odd", int'(q_o), 12);

      // wrap and saturate, both directions
      step(1'b1, 1'b0, 1'b1, 1'b0, 8, 0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
      chk("up_9", int'(q_w), 9);
      chk("co_at_9", int'(co_w), 1);
      chk("ovf_pre", int'(ovf_w), 0);
      tick();
      chk("wrap_0", int'(q_w), 0);
      chk("ovf_wrap", int'(ovf_w), 1);
      chk("tens_inc", int'(q_t), 1);
      chk("sat_9", int'(q_s), 9);
      tick();
      chk("up_1", int'(q_w), 1);
      chk("sat_hold", int'(q_s), 9);
      chk("sat_ovf", int'(ovf_s), 1);
      drv(1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
      #1;
      chk("sat_co_dn", int'(co_s), 0);
      tick();
      chk("dn_0", int'(q_w), 0);
      chk("co_at_0", int'(co_w), 1);
      chk("sat_dn_8", int'(q_s), 8);
      tick();
      chk("dn_wrap_9", int'(q_w), 9);

      // enable and priority
      step(1'b1, 1'b0, 1'b1, 1'b0, 5, 0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      chk("en0_hold", int'(q_w), 5);
      step(1'b1, 1'b1, 1'b1, 1'b0, 2, 0);
      chk("load_wins", int'(q_w), 2);
      chk("load_clr_ovf", int'(ovf_w), 0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      chk("ci0_hold", int'(q_w), 2);

      // cascade
      step(1'b1, 1'b0, 1'b1, 1'b0, 9, 1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
      chk("casc_up_u", int'(q_w), 0);
      chk("casc_up_t", int'(q_t), 2);
      step(1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
      chk("casc_dn_u", int'(q_w), 9);
      chk("casc_dn_t", int'(q_t), 1);
      step(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
      drv(1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
      #1;
      chk("casc_co_t", int'(co_t), 1);
      tick();
      chk("casc_99_u", int'(q_w), 9);
      chk("casc_99_t", int'(q_t), 9);

      // async reset mid-count, then resume
      step(1'b1, 1'b0, 1'b1, 1'b0, 4, 0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
      async_reset(1'b1);
      chk("rel_edge_q", int'(q_w), 0);
      tick();
      chk("resume_q", int'(q_w), 1);

      // randomised traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            async_reset(1'b0);
         end else begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
         end
      end

      @(negedge clk);
      #5;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
